// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer
// Collects bytes from uart_rx until the buffer is full or a terminator
// arrives, then replays the stored line to uart_tx in arrival order
// (MODE 0) or reversed (MODE 1). Bytes received during a replay are dropped
// and reported with a one-cycle rx_drop pulse.
module uart_echo_buffer #(
    parameter int         DATA_W    = 8,
    parameter int         DEPTH     = 16,
    parameter int         MODE      = 0,
    parameter int         USE_TERM  = 1,
    parameter logic [7:0] TERM_CHAR = 8'h0D
) (
    input  logic                         hwclk,
    input  logic                         rst,
    input  logic                         rx_dv,
    input  logic [DATA_W-1:0]            rx_byte,
    input  logic                         tx_active,
    input  logic                         tx_done,
    output logic                         tx_dv,
    output logic [DATA_W-1:0]            tx_byte,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         rx_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    // Terminator compared over the low DATA_W bits (zero-extended if wider).
    localparam logic [DATA_W-1:0] TERM_VAL = DATA_W'(TERM_CHAR);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic is_term;
    logic fill_store;
    logic full_trigger;
    logic term_trigger;
    logic tx_ack;
    logic last_ack;

    // A terminator only means something when terminator replay is enabled.
    assign is_term      = (USE_TERM != 0) && (rx_byte == TERM_VAL);
    // Non-terminator byte in FILL is always stored (full trigger guarantees room).
    assign fill_store   = (state == S_FILL) && rx_dv && !is_term;
    // The store that makes the buffer full also starts the replay.
    assign full_trigger = fill_store && (count == CNT_LAST);
    // A terminator with an empty buffer is silently ignored.
    assign term_trigger = (state == S_FILL) && rx_dv && is_term && (count != '0);
    // tx_done only counts while waiting for the byte we launched.
    assign tx_ack       = (state == S_WAIT) && tx_done;
    assign last_ack     = tx_ack && (count == CNT_ONE);

    // State register.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_FILL: begin
                if (full_trigger || term_trigger) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_SEND;
            end
            S_SEND: begin
                if (!tx_active) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_ack) begin
                    state_next = last_ack ? S_FILL : S_LOAD;
                end
            end
            default: begin
                state_next = S_FILL;
            end
        endcase
    end

    // Outputs: the start strobe is gated by tx_active so it can never overlap
    // a transmission, and it vanishes as soon as reset forces FILL.
    always_comb begin
        tx_dv = (state == S_SEND) && !tx_active;
        busy  = (state != S_FILL);
    end

    // Line storage: plain write port, read is registered through tx_byte.
    always_ff @(posedge hwclk) begin
        if (fill_store) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    // Occupancy count and read/write pointers.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fill_store) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                count  <= count + CNT_ONE;
            end

            // Reverse replay starts at the newest byte; in FILL wr_ptr equals
            // count, so the newest entry is wr_ptr-1 (or wr_ptr itself when the
            // store that fills the buffer is happening this cycle).
            if (MODE != 0) begin
                if (full_trigger) begin
                    rd_ptr <= wr_ptr;
                end else if (term_trigger) begin
                    rd_ptr <= wr_ptr - PTR_ONE;
                end
            end

            if (tx_ack) begin
                count <= count - CNT_ONE;
                if (last_ack) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else if (MODE == 0) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end else begin
                    rd_ptr <= rd_ptr - PTR_ONE;
                end
            end
        end
    end

    // Byte presented to uart_tx; held from LOAD until the next LOAD.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            tx_byte <= '0;
        end else if (state == S_LOAD) begin
            tx_byte <= mem[rd_ptr];
        end
    end

    // Flag bytes that arrive while a replay owns the buffer.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            rx_drop <= 1'b0;
        end else begin
            rx_drop <= rx_dv && (state != S_FILL);
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer: a FIFO instance (DEPTH 4, no
// terminator) and a LIFO instance (DEPTH 4, terminator 0D), each driven by a
// small uart_tx responder that records every launched byte.
module tb_uart_echo_buffer;

    localparam int TX_LAT = 4;

    logic hwclk = 1'b0;
    logic rst;

    logic [1:0] rx_dv;
    logic [7:0] rx_byte [2];
    logic [1:0] hold_active;
    logic [1:0] resp_active = 2'b00;
    logic [1:0] tx_done     = 2'b00;
    int         resp_cnt [2] = '{0, 0};
    logic [7:0] resp_byte [2];
    logic [7:0] sent_buf [2][64];
    int         sent_n [2] = '{0, 0};

    wire  [1:0] tx_active = resp_active | hold_active;
    wire  [1:0] tx_dv;
    wire  [1:0] busy;
    wire  [1:0] rx_drop;
    wire  [7:0] tx_byte [2];
    wire  [2:0] count [2];

    int total = 0;
    int bad   = 0;

    always #5 hwclk = ~hwclk;

    uart_echo_buffer #(
        .DATA_W(8), .DEPTH(4), .MODE(0), .USE_TERM(0), .TERM_CHAR(8'h0D)
    ) dut_fifo (
        .hwclk(hwclk), .rst(rst),
        .rx_dv(rx_dv[0]), .rx_byte(rx_byte[0]),
        .tx_active(tx_active[0]), .tx_done(tx_done[0]),
        .tx_dv(tx_dv[0]), .tx_byte(tx_byte[0]),
        .count(count[0]), .busy(busy[0]), .rx_drop(rx_drop[0])
    );

    uart_echo_buffer #(
        .DATA_W(8), .DEPTH(4), .MODE(1), .USE_TERM(1), .TERM_CHAR(8'h0D)
    ) dut_lifo (
        .hwclk(hwclk), .rst(rst),
        .rx_dv(rx_dv[1]), .rx_byte(rx_byte[1]),
        .tx_active(tx_active[1]), .tx_done(tx_done[1]),
        .tx_dv(tx_dv[1]), .tx_byte(tx_byte[1]),
        .count(count[1]), .busy(busy[1]), .rx_drop(rx_drop[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // uart_tx stand-in: start on tx_dv, stay active TX_LAT cycles, pulse tx_done.
    always @(posedge hwclk) begin
        for (int d = 0; d < 2; d++) begin
            tx_done[d] <= 1'b0;
            if (resp_active[d]) begin
                if (resp_cnt[d] == 1) begin
                    resp_active[d] <= 1'b0;
                    tx_done[d]     <= 1'b1;
                end
                resp_cnt[d] <= resp_cnt[d] - 1;
            end else if (tx_dv[d]) begin
                $display("dut%0d tx %02h", d, tx_byte[d]);
                resp_active[d] <= 1'b1;
                resp_cnt[d]    <= TX_LAT;
                resp_byte[d]   <= tx_byte[d];
                if (sent_n[d] < 64) begin
                    sent_buf[d][sent_n[d]] <= tx_byte[d];
                end
                sent_n[d] <= sent_n[d] + 1;
            end
        end
    end

    // Continuous protocol checks away from the active edge.
    always @(negedge hwclk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst && tx_active[d]) begin
                check("dv_while_active", {31'd0, tx_dv[d]}, 32'd0);
            end
            if (!rst && tx_done[d]) begin
                check("tx_byte_stable", {24'd0, tx_byte[d]}, {24'd0, resp_byte[d]});
            end
        end
    end

    task automatic send_rx(input int d, input logic [7:0] b);
        @(negedge hwclk);
        $display("dut%0d rx %02h", d, b);
        rx_dv[d]   = 1'b1;
        rx_byte[d] = b;
        @(negedge hwclk);
        rx_dv[d]   = 1'b0;
    endtask

    // Follow tx_done strobes; after each, count must drop by one and busy must
    // fall exactly when the count reaches zero.
    task automatic wait_replay(input int d, input int n, input int stop);
        int rem;
        int seen;
        int cyc;
        rem  = n;
        seen = 0;
        cyc  = 0;
        while (seen < stop && cyc < 2000) begin
            @(negedge hwclk);
            cyc++;
            if (tx_done[d]) begin
                rem--;
                seen++;
                @(negedge hwclk);
                check("count_after_done", {29'd0, count[d]}, rem);
                check("busy_after_done", {31'd0, busy[d]}, {31'd0, rem != 0});
            end
        end
        if (seen < stop) begin
            check("replay_timeout", seen, stop);
        end
    endtask

    task automatic check_sent(input int d, input int base, input int n, input logic [31:0] exp_bytes);
        check("sent_count", sent_n[d] - base, n);
        for (int k = 0; k < n; k++) begin
            check("sent_byte", {24'd0, sent_buf[d][base + k]}, {24'd0, exp_bytes[8*(n-1-k) +: 8]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        rst         = 1'b1;
        rx_dv       = 2'b00;
        rx_byte[0]  = 8'h00;
        rx_byte[1]  = 8'h00;
        hold_active = 2'b00;
        repeat (3) @(negedge hwclk);
        for (int d = 0; d < 2; d++) begin
            check("rst_count",   {29'd0, count[d]},   32'd0);
            check("rst_busy",    {31'd0, busy[d]},    32'd0);
            check("rst_tx_dv",   {31'd0, tx_dv[d]},   32'd0);
            check("rst_tx_byte", {24'd0, tx_byte[d]}, 32'd0);
            check("rst_rx_drop", {31'd0, rx_drop[d]}, 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge hwclk);

        // FIFO, full trigger.
        base = sent_n[0];
        send_rx(0, 8'h41);
        send_rx(0, 8'h42);
        send_rx(0, 8'h43);
        check("fill_count3", {29'd0, count[0]}, 32'd3);
        check("fill_busy",   {31'd0, busy[0]},  32'd0);
        send_rx(0, 8'h44);
        check("full_count4", {29'd0, count[0]}, 32'd4);
        check("full_busy",   {31'd0, busy[0]},  32'd1);
        check("load_no_dv",  {31'd0, tx_dv[0]}, 32'd0);
        @(negedge hwclk);
        check("start_dv",      {31'd0, tx_dv[0]},   32'd1);
        check("start_tx_byte", {24'd0, tx_byte[0]}, 32'h41);
        wait_replay(0, 4, 4);
        check_sent(0, base, 4, 32'h41424344);

        // FIFO with terminator disabled: 0D is ordinary data.
        base = sent_n[0];
        send_rx(0, 8'h0D);
        check("noterm_count1", {29'd0, count[0]}, 32'd1);
        send_rx(0, 8'h01);
        send_rx(0, 8'h02);
        send_rx(0, 8'h03);
        wait_replay(0, 4, 4);
        check_sent(0, base, 4, 32'h0D010203);

        // LIFO, terminator trigger.
        base = sent_n[1];
        send_rx(1, 8'h61);
        send_rx(1, 8'h62);
        send_rx(1, 8'h63);
        check("lifo_count3", {29'd0, count[1]}, 32'd3);
        send_rx(1, 8'h0D);
        check("term_count3", {29'd0, count[1]}, 32'd3);
        check("term_busy",   {31'd0, busy[1]},  32'd1);
        wait_replay(1, 3, 3);
        check_sent(1, base, 3, 32'h00636261);

        // Lone terminator with an empty buffer.
        base = sent_n[1];
        send_rx(1, 8'h0D);
        check("lone_count",   {29'd0, count[1]},   32'd0);
        check("lone_busy",    {31'd0, busy[1]},    32'd0);
        check("lone_rx_drop", {31'd0, rx_drop[1]}, 32'd0);
        repeat (10) @(negedge hwclk);
        check("lone_no_tx", sent_n[1] - base, 32'd0);
        check("lone_idle",  {31'd0, busy[1]}, 32'd0);

        // Single-byte line.
        base = sent_n[1];
        send_rx(1, 8'h5A);
        send_rx(1, 8'h0D);
        wait_replay(1, 1, 1);
        check_sent(1, base, 1, 32'h0000005A);

        // Drop during replay.
        base = sent_n[1];
        send_rx(1, 8'h71);
        send_rx(1, 8'h72);
        send_rx(1, 8'h0D);
        send_rx(1, 8'h55);
        check("drop_pulse", {31'd0, rx_drop[1]}, 32'd1);
        @(negedge hwclk);
        check("drop_single", {31'd0, rx_drop[1]}, 32'd0);
        wait_replay(1, 2, 2);
        check_sent(1, base, 2, 32'h00007271);

        // Back-pressure: tx_active held high while in SEND.
        base = sent_n[0];
        hold_active[0] = 1'b1;
        send_rx(0, 8'h11);
        send_rx(0, 8'h22);
        send_rx(0, 8'h33);
        send_rx(0, 8'h44);
        @(negedge hwclk);
        for (int i = 0; i < 20; i++) begin
            check("hold_no_dv",   {31'd0, tx_dv[0]},   32'd0);
            check("hold_tx_byte", {24'd0, tx_byte[0]}, 32'h11);
            @(negedge hwclk);
        end
        hold_active[0] = 1'b0;
        #1;
        check("release_dv", {31'd0, tx_dv[0]}, 32'd1);
        @(negedge hwclk);
        check("release_dv_one", {31'd0, tx_dv[0]}, 32'd0);
        wait_replay(0, 4, 4);
        check_sent(0, base, 4, 32'h11223344);

        // Reset mid-replay after the second tx_done.
        base = sent_n[0];
        send_rx(0, 8'hA1);
        send_rx(0, 8'hA2);
        send_rx(0, 8'hA3);
        send_rx(0, 8'hA4);
        wait_replay(0, 4, 2);
        rst = 1'b1;
        #1;
        check("midrst_tx_dv", {31'd0, tx_dv[0]},  32'd0);
        check("midrst_count", {29'd0, count[0]}, 32'd0);
        check("midrst_busy",  {31'd0, busy[0]},  32'd0);
        @(negedge hwclk);
        rst = 1'b0;
        repeat (8) @(negedge hwclk);
        check_sent(0, base, 2, 32'h0000A1A2);
        check("postrst_busy", {31'd0, busy[0]}, 32'd0);
        base = sent_n[0];
        send_rx(0, 8'h31);
        send_rx(0, 8'h32);
        send_rx(0, 8'h33);
        send_rx(0, 8'h34);
        wait_replay(0, 4, 4);
        check_sent(0, base, 4, 32'h31323334);

        repeat (4) @(negedge hwclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
